// File: rtl/ff_write_arbiter_pkg.sv
// Shared definitions for the ff_write_arbiter block.
//   arb_state_e  : two-state arbiter FSM encoding (IDLE / OWN)
//   DEF_*        : default parameter values for the top level
package ff_write_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

  localparam int DEF_NREQ     = 4;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_MAX_HOLD = 4;

endpackage

// File: rtl/ff_write_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   i_req     : request vector, one bit per requester
//   i_rr_ptr  : index of the most recent grantee (lowest priority)
//   o_pick    : first requester with req set, searching upward from i_rr_ptr+1 with wrap
//   o_any_req : at least one request bit is set
module ff_write_arbiter_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_rr_ptr,
  output logic [PW-1:0]   o_pick,
  output logic            o_any_req
);

  function automatic logic [PW-1:0] wrap_idx(input int v);
    return PW'(v % NREQ);
  endfunction

  // Walk from the farthest candidate to the nearest so the nearest set bit
  // overwrites the others and ends up as the pick.
  always_comb begin
    o_pick    = '0;
    o_any_req = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (i_req[wrap_idx(int'(i_rr_ptr) + k)]) begin
        o_pick    = wrap_idx(int'(i_rr_ptr) + k);
        o_any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ff_write_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among NREQ requesters.
//   clk, rst  : clock, synchronous active-high reset
//   req       : per-requester level request
//   wr_data   : packed data words, requester i at [i*WIDTH +: WIDTH]
//   wr_last   : per-requester "final word" marker
//   gnt       : registered one-hot grant (zero when idle)
//   owner     : current or most recent grantee
//   busy      : high while a grant is held
//   q         : shared register
//   q_valid   : sticky, set by the first write after reset
module ff_write_arbiter
  import ff_write_arbiter_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   wr_data,
  input  logic [NREQ-1:0]         wr_last,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy,
  output logic [WIDTH-1:0]        q,
  output logic                    q_valid
);

  localparam int PW = $clog2(NREQ);
  localparam int HW = $clog2(MAX_HOLD + 1);

  arb_state_e        r_state, w_state_nxt;
  logic [NREQ-1:0]   r_gnt, w_gnt_nxt;
  logic [PW-1:0]     r_owner, w_owner_nxt;
  logic [PW-1:0]     r_rr_ptr, w_rr_nxt;
  logic [HW-1:0]     r_hold_cnt, w_hold_nxt;
  logic [WIDTH-1:0]  r_q, w_q_nxt;
  logic              r_q_valid, w_qv_nxt;

  logic [PW-1:0]     w_pick;
  logic              w_any_req;
  logic              w_wr;
  logic              w_final;
  logic [WIDTH-1:0]  w_data_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_split
    assign w_data_arr[g] = wr_data[g*WIDTH +: WIDTH];
  end

  ff_write_arbiter_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .i_req     (req),
    .i_rr_ptr  (r_rr_ptr),
    .o_pick    (w_pick),
    .o_any_req (w_any_req)
  );

  // The owner writes exactly in the cycles it keeps its request up.
  assign w_wr    = (r_state == ST_OWN) && req[r_owner];
  // Last write of this grant: requester says so, or the hold limit is reached.
  assign w_final = wr_last[r_owner] || (r_hold_cnt == HW'(MAX_HOLD - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_any_req)         w_state_nxt = ST_OWN;
      ST_OWN:  if (!w_wr || w_final)  w_state_nxt = ST_IDLE;
      default:                        w_state_nxt = ST_IDLE;
    endcase
  end

  // Output / datapath next values; everything lands in flops below so no
  // input reaches an output combinationally.
  always_comb begin
    w_gnt_nxt   = '0;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr_ptr;
    w_hold_nxt  = r_hold_cnt;
    w_q_nxt     = r_q;
    w_qv_nxt    = r_q_valid;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_gnt_nxt   = NREQ'(1) << w_pick;
          w_owner_nxt = w_pick;
          w_rr_nxt    = w_pick;
          w_hold_nxt  = '0;
        end
      end
      ST_OWN: begin
        if (w_wr) begin
          w_q_nxt    = w_data_arr[r_owner];
          w_qv_nxt   = 1'b1;
          w_hold_nxt = r_hold_cnt + HW'(1);
          if (!w_final) w_gnt_nxt = r_gnt;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt      <= '0;
      r_owner    <= '0;
      r_rr_ptr   <= PW'(NREQ - 1);  // requester 0 gets first priority
      r_hold_cnt <= '0;
      r_q        <= '0;
      r_q_valid  <= 1'b0;
    end else begin
      r_gnt      <= w_gnt_nxt;
      r_owner    <= w_owner_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_q        <= w_q_nxt;
      r_q_valid  <= w_qv_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign owner   = r_owner;
  assign busy    = (r_state == ST_OWN);
  assign q       = r_q;
  assign q_valid = r_q_valid;

endmodule

// File: tb/tb_ff_write_arbiter.sv
module tb_ff_write_arbiter;

  localparam int NREQ = 4;
  localparam int WIDTH = 8;
  localparam int MAXH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] wr_data;
  logic [3:0]  wr_last;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        busy;
  logic [7:0]  q;
  logic        q_valid;

  ff_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .rst(rst), .req(req), .wr_data(wr_data), .wr_last(wr_last),
    .gnt(gnt), .owner(owner), .busy(busy), .q(q), .q_valid(q_valid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: who holds the register, how many words it has written,
  // who was served last, and what the register holds.
  bit         m_own;
  int         m_owner;
  int         m_writes;
  int         m_rr;
  logic [7:0] m_q;
  bit         m_qv;

  task automatic model_step(input logic r, input logic [3:0] rq,
                            input logic [31:0] d, input logic [3:0] l);
    int c;
    if (r) begin
      m_own = 0; m_owner = 0; m_writes = 0; m_rr = NREQ - 1; m_q = '0; m_qv = 0;
    end else if (!m_own) begin
      if (rq != 4'b0) begin
        for (int k = 1; k <= NREQ; k++) begin
          c = (m_rr + k) % NREQ;
          if (rq[c]) begin
            m_owner = c;
            break;
          end
        end
        m_rr = m_owner; m_own = 1; m_writes = 0;
      end
    end else if (rq[m_owner]) begin
      m_q = d[m_owner*8 +: 8];
      m_qv = 1;
      m_writes++;
      if (l[m_owner] || m_writes == MAXH) m_own = 0;
    end else begin
      m_own = 0;
    end
  endtask

  task automatic cyc(input logic r, input logic [3:0] rq,
                     input logic [31:0] d, input logic [3:0] l);
    @(negedge clk);
    rst = r; req = rq; wr_data = d; wr_last = l;
    @(posedge clk);
    model_step(r, rq, d, l);
    #1;
    chk("gnt",     32'(gnt),     m_own ? (32'd1 << m_owner) : 32'd0);
    chk("owner",   32'(owner),   32'(m_owner));
    chk("busy",    32'(busy),    32'(m_own));
    chk("q",       32'(q),       32'(m_q));
    chk("q_valid", 32'(q_valid), 32'(m_qv));
  endtask

  // Data bus with lane i set to v and the other lanes random.
  function automatic logic [31:0] put(input int i, input logic [7:0] v);
    logic [31:0] w;
    w = $urandom;
    w[i*8 +: 8] = v;
    return w;
  endfunction

  task automatic do_reset();
    cyc(1'b1, 4'($urandom), $urandom, 4'($urandom));
  endtask

  int          grants[$];
  int          runs[$];
  int          run;
  logic [3:0]  prev_gnt;

  initial begin
    rst = 1'b1; req = '0; wr_data = '0; wr_last = '0;

    // 1. reset with random inputs
    do_reset();
    do_reset();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_q", 32'(q), 0);
    chk("rst_qv", 32'(q_valid), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_busy", 32'(busy), 0);

    // 2. single requester, two words, last on the second
    cyc(0, 4'b0100, put(2, 8'hA5), 4'b0000);
    chk("t2_gnt", 32'(gnt), 32'h4);
    cyc(0, 4'b0100, put(2, 8'hA5), 4'b0000);
    chk("t2_q1", 32'(q), 32'hA5);
    cyc(0, 4'b0100, put(2, 8'h3C), 4'b0100);
    chk("t2_q2", 32'(q), 32'h3C);
    chk("t2_gnt_off", 32'(gnt), 0);
    cyc(0, 4'b0000, $urandom, 4'b0000);
    chk("t2_q_hold", 32'(q), 32'h3C);

    // 3. all requesters held high
    do_reset();
    prev_gnt = '0;
    run = 0;
    for (int i = 0; i < 26; i++) begin
      cyc(0, 4'b1111, $urandom, 4'b0000);
      if (gnt != 0 && prev_gnt == 0) begin
        grants.push_back(int'(owner));
        run = 0;
      end
      if (gnt != 0) run++;
      if (gnt == 0 && prev_gnt != 0) runs.push_back(run);
      prev_gnt = gnt;
    end
    chk("t3_ngrants", 32'(grants.size() >= 5), 1);
    for (int i = 0; i < 5; i++)
      chk("t3_order", (i < grants.size()) ? 32'(grants[i]) : 32'hDEAD, 32'(i % 4));
    chk("t3_nruns", 32'(runs.size() >= 4), 1);
    for (int i = 0; i < 4; i++)
      chk("t3_writes", (i < runs.size()) ? 32'(runs[i]) : 32'hDEAD, 32'd4);

    // 4. owner 1 drops its request after two writes
    do_reset();
    cyc(0, 4'b0010, put(1, 8'h00), 4'b0000);
    chk("t4_gnt", 32'(gnt), 32'h2);
    cyc(0, 4'b0010, put(1, 8'h11), 4'b0000);
    cyc(0, 4'b0010, put(1, 8'h22), 4'b0000);
    cyc(0, 4'b1000, put(1, 8'h33), 4'b0000);
    chk("t4_q", 32'(q), 32'h22);
    chk("t4_busy", 32'(busy), 0);
    cyc(0, 4'b1000, $urandom, 4'b0000);
    chk("t4_gnt3", 32'(gnt), 32'h8);

    // 5. reset in the middle of owner 2's third write
    do_reset();
    cyc(0, 4'b0100, $urandom, 4'b0000);
    cyc(0, 4'b0100, put(2, 8'h51), 4'b0000);
    cyc(0, 4'b0100, put(2, 8'h52), 4'b0000);
    cyc(1, 4'b0100, put(2, 8'h53), 4'b0000);
    chk("t5_q", 32'(q), 0);
    chk("t5_qv", 32'(q_valid), 0);
    chk("t5_gnt", 32'(gnt), 0);
    cyc(0, 4'b1111, $urandom, 4'b0000);
    chk("t5_regnt", 32'(gnt), 32'h1);

    // 6. wr_last on the first granted cycle
    cyc(0, 4'b0001, put(0, 8'h7E), 4'b0001);
    chk("t6_q", 32'(q), 32'h7E);
    chk("t6_busy", 32'(busy), 0);
    cyc(0, 4'b0000, $urandom, 4'b0000);
    chk("t6_q_hold", 32'(q), 32'h7E);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(0, 99) == 0), 4'($urandom), $urandom,
          ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
